// File: rtl/solver_pkg.sv
// Shared definitions for the MCMC solver sequencer and its LFSR.
package solver_pkg;

    localparam int unsigned DEFAULT_ITER_WIDTH = 16;
    localparam logic [15:0] LFSR_MASK          = 16'hB400;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        EVAL,
        EVAL_WAIT,
        SELECT,
        MOVE,
        MOVE_WAIT,
        WRITE,
        DONE
    } state_e;

endpackage

// File: rtl/solver_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), free-running from reset.
module solver_lfsr16
    import solver_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_MASK : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/solver_controller.sv
// Top-level sequencer: load, evaluate, pick a move type, move, write back, repeat.
module solver_controller
    import solver_pkg::*;
#(
    parameter int unsigned ITER_WIDTH = DEFAULT_ITER_WIDTH,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ITER_WIDTH-1:0] max_iterations,
    input  logic [7:0]            in_pls0,
    output logic                  assignment_selector,
    output logic                  storage_we,
    output logic                  eval_start,
    input  logic                  eval_done,
    input  logic                  all_satisfied,
    output logic                  move_start,
    output logic                  move_is_local,
    input  logic                  move_done,
    output logic                  busy,
    output logic                  done,
    output logic                  solved,
    output logic [ITER_WIDTH-1:0] iteration_count
);

    state_e                state_q, state_d;
    logic [ITER_WIDTH-1:0] max_iter_q, max_iter_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;
    logic [7:0]            pls0_q, pls0_d;
    logic                  solved_q, solved_d;
    logic                  local_q, local_d;
    logic                  sel_q, sel_d;
    logic                  we_q, we_d;
    logic                  eval_start_q, eval_start_d;
    logic                  move_start_q, move_start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [15:0] lfsr;
    logic [7:0]  rnd;
    logic [7:0]  lfsr_unused;

    solver_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr)
    );

    assign {lfsr_unused, rnd} = lfsr;

    always_comb begin
        state_d    = state_q;
        max_iter_d = max_iter_q;
        iter_d     = iter_q;
        pls0_d     = pls0_q;
        solved_d   = solved_q;
        local_d    = local_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    max_iter_d = max_iterations;
                    pls0_d     = in_pls0;
                    iter_d     = '0;
                    solved_d   = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD:  state_d = EVAL;
            EVAL:  state_d = EVAL_WAIT;
            EVAL_WAIT: begin
                // Budget is checked before any increment, so the counter cannot wrap.
                if (eval_done) begin
                    if (all_satisfied) begin
                        solved_d = 1'b1;
                        state_d  = DONE;
                    end else if (iter_q == max_iter_q) begin
                        solved_d = 1'b0;
                        state_d  = DONE;
                    end else begin
                        state_d = SELECT;
                    end
                end
            end
            SELECT: begin
                local_d = (rnd < pls0_q);
                state_d = MOVE;
            end
            MOVE: state_d = MOVE_WAIT;
            MOVE_WAIT: begin
                if (move_done) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                iter_d  = iter_q + ITER_WIDTH'(1);
                state_d = EVAL;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        sel_d        = (state_d == WRITE);
        we_d         = (state_d == LOAD) || (state_d == WRITE);
        eval_start_d = (state_d == EVAL);
        move_start_d = (state_d == MOVE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            max_iter_q   <= '0;
            iter_q       <= '0;
            pls0_q       <= '0;
            solved_q     <= 1'b0;
            local_q      <= 1'b0;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            eval_start_q <= 1'b0;
            move_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            max_iter_q   <= max_iter_d;
            iter_q       <= iter_d;
            pls0_q       <= pls0_d;
            solved_q     <= solved_d;
            local_q      <= local_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            eval_start_q <= eval_start_d;
            move_start_q <= move_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign assignment_selector = sel_q;
    assign storage_we          = we_q;
    assign eval_start          = eval_start_q;
    assign move_start          = move_start_q;
    assign move_is_local       = local_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign solved              = solved_q;
    assign iteration_count     = iter_q;

endmodule

// File: tb/tb_solver_controller.sv
// Scoreboard bench for solver_controller with eval/move responders and an LFSR reference.
module tb_solver_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] max_iterations = '0;
    logic [7:0]  in_pls0 = '0;
    logic        assignment_selector, storage_we, eval_start, move_start;
    logic        move_is_local, busy, done, solved;
    logic        eval_done = 1'b0, all_satisfied = 1'b0, move_done = 1'b0;
    logic [15:0] iteration_count;

    solver_controller #(
        .ITER_WIDTH (16),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .max_iterations      (max_iterations),
        .in_pls0             (in_pls0),
        .assignment_selector (assignment_selector),
        .storage_we          (storage_we),
        .eval_start          (eval_start),
        .eval_done           (eval_done),
        .all_satisfied       (all_satisfied),
        .move_start          (move_start),
        .move_is_local       (move_is_local),
        .move_done           (move_done),
        .busy                (busy),
        .done                (done),
        .solved              (solved),
        .iteration_count     (iteration_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        solved;
        int unsigned iters;
        int unsigned moves;
        int unsigned evals;
        int unsigned writes;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Responder configuration
    int   eval_delay = 1;
    int   move_delay = 2;
    int   sat_at = -1;
    int   eval_idx = 0;
    bit   stray = 1'b0;
    int   cur_pls = 0;

    logic [15:0] model_lfsr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_lfsr <= 16'hACE1;
        else        model_lfsr <= {1'b0, model_lfsr[15:1]} ^ (model_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic s, input int unsigned it, input int unsigned mv,
                                input int unsigned ev, input int unsigned wr);
        exp_t e;
        e.solved = s; e.iters = it; e.moves = mv; e.evals = ev; e.writes = wr;
        return e;
    endfunction

    // Eval/move responders, with optional stray handshakes outside the wait states.
    initial begin
        int ev_cnt = 0;
        int mv_cnt = 0;
        forever begin
            @(negedge clk);
            eval_done = 1'b0; move_done = 1'b0; all_satisfied = 1'b0;
            if (!rst_n) begin
                ev_cnt = 0; mv_cnt = 0;
            end else begin
                if (ev_cnt > 0) begin
                    if (stray) move_done = 1'b1;
                    ev_cnt--;
                    if (ev_cnt == 0) begin
                        eval_done = 1'b1;
                        all_satisfied = (eval_idx == sat_at);
                        eval_idx++;
                    end
                end
                if (mv_cnt > 0) begin
                    if (stray) begin eval_done = 1'b1; all_satisfied = 1'b1; end
                    mv_cnt--;
                    if (mv_cnt == 0) move_done = 1'b1;
                end
                if (eval_start) ev_cnt = eval_delay;
                if (move_start) mv_cnt = move_delay;
            end
        end
    end

    // Monitor: per-run counts, load/eval timing, move type against LFSR model, done scoreboard.
    initial begin
        logic        busy_prev = 1'b0;
        logic [15:0] last_lfsr = 16'hACE1;
        int unsigned cyc = 0, mv = 0, ev = 0, wr = 0;
        bit          pend = 1'b0;
        logic        exp_local = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_prev = 1'b0; cyc = 0; pend = 1'b0;
            end else begin
                if (busy && !busy_prev) begin
                    cyc = 0; mv = 0; ev = 0; wr = 0;
                    chk("load_we", {31'b0, storage_we}, 1);
                    chk("load_selector", {31'b0, assignment_selector}, 0);
                    chk("load_iter_cleared", {16'b0, iteration_count}, 0);
                    chk("load_solved_cleared", {31'b0, solved}, 0);
                end
                if (busy) begin
                    cyc++;
                    if (cyc == 2) chk("eval_start_timing", {31'b0, eval_start}, 1);
                end
                if (eval_start) ev++;
                if (storage_we && assignment_selector) wr++;
                if (pend) begin
                    chk("move_is_local_stable", {31'b0, move_is_local}, {31'b0, exp_local});
                    pend = 1'b0;
                end
                if (move_start) begin
                    mv++;
                    exp_local = (int'(last_lfsr[7:0]) < cur_pls);
                    chk("move_is_local", {31'b0, move_is_local}, {31'b0, exp_local});
                    pend = 1'b1;
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_done: got done pulse, expected none at %0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_solved", {31'b0, solved}, {31'b0, e.solved});
                        chk("done_iteration_count", {16'b0, iteration_count}, e.iters);
                        chk("done_move_starts", mv, e.moves);
                        chk("done_eval_starts", ev, e.evals);
                        chk("done_write_cycles", wr, e.writes);
                    end
                end
                busy_prev = busy;
            end
            last_lfsr = model_lfsr;
        end
    end

    task automatic run_start(input int unsigned maxit, input int unsigned pls, input bit push, input exp_t e);
        @(negedge clk);
        max_iterations = maxit[15:0];
        in_pls0 = pls[7:0];
        cur_pls = int'(pls);
        eval_idx = 0;
        start = 1'b1;
        if (push) sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("start_accept_busy", {31'b0, busy}, 1);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb_q.size() != 0) && n < budget);
        if (n >= budget) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: busy=%0b pending=%0d expected idle", nm, busy, sb_q.size());
        end
    endtask

    task automatic wait_signal(input int which, input int budget, input string nm);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0: seen = move_start;
                1: seen = eval_start;
                default: seen = done;
            endcase
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: signal not seen, expected within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {23'b0, assignment_selector, storage_we, eval_start, move_start,
                              move_is_local, busy, done, solved}, 0);
        chk("reset_lfsr_seed", {16'b0, dut.lfsr}, 32'hACE1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Solved on first evaluation
        run_start(5, 100, 1'b1, mk(1'b1, 0, 0, 1, 0));
        sat_at = 0;
        wait_idle(200, "solved_first");
        sat_at = -1;

        // Budget exhausted after 3 moves
        run_start(3, 128, 1'b1, mk(1'b0, 3, 3, 4, 3));
        wait_idle(500, "budget3");

        // Zero budget: single evaluation
        run_start(0, 200, 1'b1, mk(1'b0, 0, 0, 1, 0));
        wait_idle(200, "budget0");

        // Solved on the third evaluation
        sat_at = 2;
        run_start(10, 77, 1'b1, mk(1'b1, 2, 2, 3, 2));
        wait_idle(500, "solved_third");
        sat_at = -1;

        // Probability boundaries
        run_start(20, 0, 1'b1, mk(1'b0, 20, 20, 21, 20));
        wait_idle(2000, "pls0_zero");
        run_start(20, 255, 1'b1, mk(1'b0, 20, 20, 21, 20));
        wait_idle(2000, "pls0_max");
        run_start(200, 128, 1'b1, mk(1'b0, 200, 200, 201, 200));
        wait_idle(5000, "pls0_half");

        // Stray handshakes and starts while busy / in DONE
        eval_delay = 3; move_delay = 3; stray = 1'b1;
        run_start(2, 90, 1'b1, mk(1'b0, 2, 2, 3, 2));
        wait_signal(1, 50, "stray_eval_start");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_signal(2, 500, "stray_done");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", {31'b0, busy}, 0);
        wait_idle(200, "stray");
        repeat (3) @(negedge clk);
        chk("stays_idle", {31'b0, busy}, 0);
        eval_delay = 1; move_delay = 2; stray = 1'b0;

        // Reset mid-run in MOVE_WAIT
        move_delay = 6;
        run_start(10, 128, 1'b0, mk(1'b0, 0, 0, 0, 0));
        wait_signal(0, 100, "rst_move1");
        wait_signal(0, 100, "rst_move2");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", {23'b0, assignment_selector, storage_we, eval_start, move_start,
                                     move_is_local, busy, done, solved}, 0);
        chk("midrun_reset_iter", {16'b0, iteration_count}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrun_reset_lfsr_seed", {16'b0, dut.lfsr}, 32'hACE1);
        move_delay = 2;
        repeat (4) @(negedge clk);
        chk("idle_after_reset", {30'b0, busy, done}, 0);

        // Normal run after reset, checks LFSR sequence restarted
        run_start(4, 150, 1'b1, mk(1'b0, 4, 4, 5, 4));
        wait_idle(500, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
